// File: rtl/ddr3_burst_writer.sv
// ddr3_burst_writer
//   Avalon-MM burst-write master for the 128-bit HPS f2h_sdram0 port. A
//   free-running stream of ADC sample words is buffered in a show-ahead FIFO.
//   cfg_num_words of those words are then written to consecutive SDRAM word
//   addresses starting at cfg_base_addr, in bursts of up to BURST_LEN beats.
//
// Ports
//   clk_clk, reset_reset         single clock, synchronous active-high reset
//   cfg_start/base_addr/num_words  capture request (base/count sampled on start)
//   in_valid, in_data            sample stream, no backpressure
//   avm_*                        Avalon-MM write master (read side tied off)
//   sts_busy, sts_done, sts_overflow, sts_words_written   capture status
//
// FSM states
//   state   | meaning
//   S_IDLE  | no capture running; waits for cfg_start
//   S_WAIT  | capture running; waits until the FIFO holds a whole burst
//   S_BURST | avm_write asserted; one beat per cycle without waitrequest
module ddr3_burst_writer #(
    parameter int ADDR_W    = 26,
    parameter int DATA_W    = 128,
    parameter int BURST_W   = 9,
    parameter int BURST_LEN = 64,
    parameter int FIFO_AW   = 9
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                cfg_start,
    input  logic [ADDR_W-1:0]   cfg_base_addr,
    input  logic [ADDR_W-1:0]   cfg_num_words,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [BURST_W-1:0]  avm_burstcount,
    output logic                avm_read,
    input  logic                avm_waitrequest,
    output logic                sts_busy,
    output logic                sts_done,
    output logic                sts_overflow,
    output logic [ADDR_W-1:0]   sts_words_written
);

    localparam int DEPTH = 2**FIFO_AW;
    localparam logic [ADDR_W-1:0]  BURST_LEN_A = ADDR_W'(BURST_LEN);
    localparam logic [BURST_W-1:0] BURST_LEN_B = BURST_W'(BURST_LEN);
    localparam logic [FIFO_AW:0]   DEPTH_C     = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]  num_words;
    logic [ADDR_W-1:0]  captured;
    logic [ADDR_W-1:0]  words_left;   // down-counter of words not yet written
    logic [ADDR_W-1:0]  next_addr;
    logic [BURST_W-1:0] beats_left;   // down-counter of beats left in the burst
    logic [BURST_W-1:0] burst_len;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   fifo_count;

    logic start_ok;
    logic burst_ready;
    logic start_burst;
    logic beat;
    logic last_beat;
    logic fifo_full;
    logic capture_ok;
    logic push;
    logic pop;
    logic drop;

    always_comb begin
        burst_len = (words_left >= BURST_LEN_A) ? BURST_LEN_B : words_left[BURST_W-1:0];
    end

    assign start_ok    = cfg_start && (state == S_IDLE);
    assign burst_ready = (32'(fifo_count) >= 32'(burst_len));
    assign fifo_full   = (fifo_count == DEPTH_C);
    assign capture_ok  = sts_busy && (captured < num_words);
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign push        = capture_ok && in_valid && (!fifo_full || pop);
    assign drop        = capture_ok && in_valid && fifo_full && !pop;
    assign pop         = beat;

    // State register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok && (cfg_num_words != '0)) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (burst_ready) begin
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (last_beat) begin
                    state_nxt = (words_left == ADDR_W'(1)) ? S_IDLE : S_WAIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM-decoded controls
    always_comb begin
        start_burst = 1'b0;
        beat        = 1'b0;
        last_beat   = 1'b0;
        case (state)
            S_WAIT:  start_burst = burst_ready;
            S_BURST: begin
                beat      = avm_write && !avm_waitrequest;
                last_beat = beat && (beats_left == BURST_W'(1));
            end
            default: ;
        endcase
    end

    // FIFO storage; contents need no reset, the pointers define emptiness.
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fifo_count        <= '0;
            num_words         <= '0;
            captured          <= '0;
            words_left        <= '0;
            next_addr         <= '0;
            beats_left        <= '0;
            avm_address       <= '0;
            avm_burstcount    <= '0;
            avm_write         <= 1'b0;
            sts_busy          <= 1'b0;
            sts_done          <= 1'b0;
            sts_overflow      <= 1'b0;
            sts_words_written <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + FIFO_AW'(1);
                captured <= captured + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (FIFO_AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (FIFO_AW+1)'(1);
                default: ;
            endcase
            if (drop) begin
                sts_overflow <= 1'b1;
            end

            // Only reachable in S_IDLE, where busy is low and push/drop/beat are idle.
            if (start_ok) begin
                num_words         <= cfg_num_words;
                words_left        <= cfg_num_words;
                next_addr         <= cfg_base_addr;
                captured          <= '0;
                sts_words_written <= '0;
                sts_overflow      <= 1'b0;
                sts_done          <= (cfg_num_words == '0);
                sts_busy          <= (cfg_num_words != '0);
            end

            if (start_burst) begin
                avm_address    <= next_addr;
                avm_burstcount <= burst_len;
                beats_left     <= burst_len;
                avm_write      <= 1'b1;
            end

            if (beat) begin
                sts_words_written <= sts_words_written + ADDR_W'(1);
                words_left        <= words_left - ADDR_W'(1);
                beats_left        <= beats_left - BURST_W'(1);
                if (last_beat) begin
                    avm_write <= 1'b0;
                    next_addr <= next_addr + ADDR_W'(avm_burstcount);
                    if (words_left == ADDR_W'(1)) begin
                        sts_done <= 1'b1;
                        sts_busy <= 1'b0;
                    end
                end
            end
        end
    end

    // Write data and byte enables are forced to zero outside a burst so that
    // every output reads 0 after reset regardless of stale FIFO contents.
    assign avm_writedata  = avm_write ? mem[rd_ptr] : '0;
    assign avm_byteenable = avm_write ? '1 : '0;
    assign avm_read       = 1'b0;

endmodule

// File: tb/tb_ddr3_burst_writer.sv
module tb_ddr3_burst_writer;

    logic         clk_clk = 1'b0;
    logic         reset_reset;
    logic         cfg_start;
    logic [25:0]  cfg_base_addr;
    logic [25:0]  cfg_num_words;
    logic         in_valid;
    logic [127:0] in_data;
    logic [25:0]  avm_address;
    logic         avm_write;
    logic [127:0] avm_writedata;
    logic [15:0]  avm_byteenable;
    logic [8:0]   avm_burstcount;
    logic         avm_read;
    logic         avm_waitrequest;
    logic         sts_busy;
    logic         sts_done;
    logic         sts_overflow;
    logic [25:0]  sts_words_written;

    ddr3_burst_writer dut (
        .clk_clk           (clk_clk),
        .reset_reset       (reset_reset),
        .cfg_start         (cfg_start),
        .cfg_base_addr     (cfg_base_addr),
        .cfg_num_words     (cfg_num_words),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .avm_address       (avm_address),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_burstcount    (avm_burstcount),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .sts_busy          (sts_busy),
        .sts_done          (sts_done),
        .sts_overflow      (sts_overflow),
        .sts_words_written (sts_words_written)
    );

    always #5 clk_clk = ~clk_clk;

    int total = 0;
    int bad   = 0;

    int  seq;
    bit  feed_en;
    int  wr_mode;           // 0: waitrequest low, 1: held high, 2: random
    int  write_seen;
    int  proto_err;
    int  burst_left;
    logic [25:0]  cur_addr;
    logic [8:0]   cur_bc;
    bit           stalled;
    logic [25:0]  st_addr;
    logic [8:0]   st_bc;
    logic [127:0] st_data;

    logic [127:0] beat_q [$];
    logic [25:0]  baddr_q[$];
    logic [8:0]   bbc_q  [$];

    function automatic logic [127:0] gen(input logic [31:0] s);
        return {s, ~s, s ^ 32'h5a5a_5a5a, s};
    endfunction

    function automatic logic [25:0] qa(input int i);
        return (i < baddr_q.size()) ? baddr_q[i] : '1;
    endfunction

    function automatic logic [8:0] qb(input int i);
        return (i < bbc_q.size()) ? bbc_q[i] : '1;
    endfunction

    function automatic int ramp_errs();
        int e = 0;
        for (int i = 0; i < beat_q.size(); i++)
            if (beat_q[i] !== gen(32'(i))) e++;
        return e;
    endfunction

    function automatic int order_errs();
        int e = 0;
        logic [127:0] w;
        logic [31:0]  s, sp;
        sp = '0;
        for (int i = 0; i < beat_q.size(); i++) begin
            w = beat_q[i];
            s = w[31:0];
            if (w !== gen(s)) e++;
            if (i > 0 && s <= sp) e++;
            sp = s;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: record what the coming edge will transfer, cross the
    // edge, check stall stability, then drive the stream and waitrequest.
    task automatic tick();
        if (!reset_reset) begin
            if (avm_write) write_seen++;
            if (avm_write && burst_left == 0) begin
                baddr_q.push_back(avm_address);
                bbc_q.push_back(avm_burstcount);
                cur_addr   = avm_address;
                cur_bc     = avm_burstcount;
                burst_left = int'(avm_burstcount);
            end
            if (avm_write && !avm_waitrequest) begin
                beat_q.push_back(avm_writedata);
                if (avm_address !== cur_addr || avm_burstcount !== cur_bc ||
                    avm_byteenable !== 16'hffff) proto_err++;
                burst_left--;
            end
            stalled = avm_write && avm_waitrequest;
            st_addr = avm_address;
            st_bc   = avm_burstcount;
            st_data = avm_writedata;
        end else begin
            burst_left = 0;
            stalled    = 1'b0;
        end
        @(negedge clk_clk);
        if (stalled && !reset_reset) begin
            if (!avm_write || avm_address !== st_addr || avm_burstcount !== st_bc ||
                avm_writedata !== st_data) proto_err++;
        end
        if (in_valid) seq++;
        in_valid = feed_en;
        in_data  = gen(32'(seq));
        avm_waitrequest = (wr_mode == 2) ? ($urandom_range(0, 1) == 1) : (wr_mode == 1);
    endtask

    task automatic start(input logic [25:0] base, input logic [25:0] num, input bit feed);
        feed_en = 1'b0;
        tick();
        seq = 0;
        beat_q.delete();
        baddr_q.delete();
        bbc_q.delete();
        proto_err     = 0;
        cfg_base_addr = base;
        cfg_num_words = num;
        cfg_start     = 1'b1;
        feed_en       = feed;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic run_until_done(input int max);
        int n = 0;
        while (!sts_done && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int ws;
        reset_reset     = 1'b1;
        cfg_start       = 1'b0;
        cfg_base_addr   = '0;
        cfg_num_words   = '0;
        in_valid        = 1'b0;
        in_data         = '0;
        avm_waitrequest = 1'b0;
        seq = 0; feed_en = 1'b0; wr_mode = 0; write_seen = 0;
        proto_err = 0; burst_left = 0; stalled = 1'b0;
        cur_addr = '0; cur_bc = '0;
        repeat (3) tick();

        chk("rst_write",  128'(avm_write), 128'(0));
        chk("rst_addr",   128'(avm_address), 128'(0));
        chk("rst_bc",     128'(avm_burstcount), 128'(0));
        chk("rst_be",     128'(avm_byteenable), 128'(0));
        chk("rst_read",   128'(avm_read), 128'(0));
        chk("rst_busy",   128'(sts_busy), 128'(0));
        chk("rst_done",   128'(sts_done), 128'(0));
        chk("rst_ovf",    128'(sts_overflow), 128'(0));
        chk("rst_ww",     128'(sts_words_written), 128'(0));
        reset_reset = 1'b0;
        tick();

        // T1: two full bursts, no stalls
        start(26'h100, 26'd128, 1'b1);
        chk("t1_busy", 128'(sts_busy), 128'(1));
        run_until_done(2000);
        chk("t1_done",   128'(sts_done), 128'(1));
        chk("t1_busy_end", 128'(sts_busy), 128'(0));
        chk("t1_ww",     128'(sts_words_written), 128'(128));
        chk("t1_beats",  128'(beat_q.size()), 128'(128));
        chk("t1_nburst", 128'(baddr_q.size()), 128'(2));
        chk("t1_a0",     128'(qa(0)), 128'(26'h100));
        chk("t1_b0",     128'(qb(0)), 128'(64));
        chk("t1_a1",     128'(qa(1)), 128'(26'h140));
        chk("t1_b1",     128'(qb(1)), 128'(64));
        chk("t1_data",   128'(ramp_errs()), 128'(0));
        chk("t1_proto",  128'(proto_err), 128'(0));
        chk("t1_ovf",    128'(sts_overflow), 128'(0));

        // T2: partial last burst
        start(26'h0, 26'd70, 1'b1);
        run_until_done(2000);
        chk("t2_done",  128'(sts_done), 128'(1));
        chk("t2_ww",    128'(sts_words_written), 128'(70));
        chk("t2_beats", 128'(beat_q.size()), 128'(70));
        ws = write_seen;
        feed_en = 1'b1;
        repeat (30) tick();
        chk("t2_no_more_write", 128'(write_seen - ws), 128'(0));
        chk("t2_ww_hold", 128'(sts_words_written), 128'(70));
        chk("t2_nburst", 128'(baddr_q.size()), 128'(2));
        chk("t2_a0", 128'(qa(0)), 128'(0));
        chk("t2_b0", 128'(qb(0)), 128'(64));
        chk("t2_a1", 128'(qa(1)), 128'(64));
        chk("t2_b1", 128'(qb(1)), 128'(6));
        chk("t2_data", 128'(ramp_errs()), 128'(0));

        // T3: random waitrequest
        wr_mode = 2;
        start(26'h100, 26'd128, 1'b1);
        run_until_done(4000);
        wr_mode = 0;
        chk("t3_done",   128'(sts_done), 128'(1));
        chk("t3_ww",     128'(sts_words_written), 128'(128));
        chk("t3_beats",  128'(beat_q.size()), 128'(128));
        chk("t3_nburst", 128'(baddr_q.size()), 128'(2));
        chk("t3_a1",     128'(qa(1)), 128'(26'h140));
        chk("t3_b1",     128'(qb(1)), 128'(64));
        chk("t3_data",   128'(ramp_errs()), 128'(0));
        chk("t3_stall_stable", 128'(proto_err), 128'(0));

        // T4: overflow while the slave stalls, then drain
        wr_mode = 1;
        start(26'h2000, 26'd1024, 1'b1);
        repeat (700) tick();
        chk("t4_ovf",        128'(sts_overflow), 128'(1));
        chk("t4_no_beats",   128'(beat_q.size()), 128'(0));
        chk("t4_write_held", 128'(avm_write), 128'(1));
        chk("t4_a0",         128'(qa(0)), 128'(26'h2000));
        wr_mode = 0;
        run_until_done(8000);
        chk("t4_done",   128'(sts_done), 128'(1));
        chk("t4_ww",     128'(sts_words_written), 128'(1024));
        chk("t4_beats",  128'(beat_q.size()), 128'(1024));
        chk("t4_order",  128'(order_errs()), 128'(0));
        chk("t4_first",  (beat_q.size() > 0) ? beat_q[0] : '1, gen(32'd0));
        chk("t4_nburst", 128'(baddr_q.size()), 128'(16));
        chk("t4_alast",  128'(qa(15)), 128'(26'h23c0));
        chk("t4_ovf_sticky", 128'(sts_overflow), 128'(1));

        // T5: zero-length request and start-while-busy
        ws = write_seen;
        start(26'h77, 26'd0, 1'b0);
        chk("t5_done_now", 128'(sts_done), 128'(1));
        chk("t5_not_busy", 128'(sts_busy), 128'(0));
        chk("t5_ovf_clr",  128'(sts_overflow), 128'(0));
        repeat (10) tick();
        chk("t5_no_write", 128'(write_seen - ws), 128'(0));
        start(26'h40, 26'd64, 1'b1);
        chk("t5_done_clr", 128'(sts_done), 128'(0));
        chk("t5_busy",     128'(sts_busy), 128'(1));
        repeat (5) tick();
        cfg_base_addr = 26'h999;
        cfg_num_words = 26'd0;
        cfg_start     = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("t5_ign_busy", 128'(sts_busy), 128'(1));
        chk("t5_ign_done", 128'(sts_done), 128'(0));
        run_until_done(2000);
        chk("t5_done",   128'(sts_done), 128'(1));
        chk("t5_ww",     128'(sts_words_written), 128'(64));
        chk("t5_a0",     128'(qa(0)), 128'(26'h40));
        chk("t5_data",   128'(ramp_errs()), 128'(0));

        // T6: reset in the middle of a burst, then a clean capture
        begin
            int n = 0;
            start(26'h300, 26'd64, 1'b1);
            while (beat_q.size() < 10 && n < 1000) begin
                tick();
                n++;
            end
            chk("t6_reached_beat10", 128'(beat_q.size()), 128'(10));
        end
        reset_reset = 1'b1;
        tick();
        chk("t6_write", 128'(avm_write), 128'(0));
        chk("t6_addr",  128'(avm_address), 128'(0));
        chk("t6_bc",    128'(avm_burstcount), 128'(0));
        chk("t6_be",    128'(avm_byteenable), 128'(0));
        chk("t6_wdata", avm_writedata, 128'(0));
        chk("t6_busy",  128'(sts_busy), 128'(0));
        chk("t6_ww",    128'(sts_words_written), 128'(0));
        reset_reset = 1'b0;
        start(26'h500, 26'd64, 1'b1);
        run_until_done(2000);
        chk("t6_done",   128'(sts_done), 128'(1));
        chk("t6_ww2",    128'(sts_words_written), 128'(64));
        chk("t6_nburst", 128'(baddr_q.size()), 128'(1));
        chk("t6_a0",     128'(qa(0)), 128'(26'h500));
        chk("t6_b0",     128'(qb(0)), 128'(64));
        chk("t6_data",   128'(ramp_errs()), 128'(0));
        chk("t6_beats",  128'(beat_q.size()), 128'(64));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
